// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the ID/EX/ME/WB datapath and hazard_ctrl.
// slave = the hazard controller, master = the pipeline driving ID metadata.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic             valid_id;
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             rs1_used_id;
   logic             rs2_used_id;
   logic [4:0]       rd_id;
   logic             ru_write_id;
   logic             mem_read_id;
   logic             mem_write_id;
   logic             branch_taken_ex;
   logic             dmem_ready;

   logic [4:0]       rs1_ex;
   logic [4:0]       rs2_ex;
   logic [4:0]       rd_me;
   logic             ru_write_me;
   logic [4:0]       rd_wb;
   logic             ru_write_wb;
   logic             stall_if;
   logic             stall_id;
   logic             flush_if_id;
   logic             bubble_ex;
   logic             freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport slave (
      input  valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id,
             ru_write_id, mem_read_id, mem_write_id, branch_taken_ex, dmem_ready,
      output rs1_ex, rs2_ex, rd_me, ru_write_me, rd_wb, ru_write_wb,
             stall_if, stall_id, flush_if_id, bubble_ex, freeze,
             mem_timeout, stall_count
   );

   modport master (
      output valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id,
             ru_write_id, mem_read_id, mem_write_id, branch_taken_ex, dmem_ready,
      input  rs1_ex, rs2_ex, rd_me, ru_write_me, rd_wb, ru_write_wb,
             stall_if, stall_id, flush_if_id, bubble_ex, freeze,
             mem_timeout, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: tracks write metadata through EX/ME/WB
// and produces stall, flush, bubble and freeze controls.
//
// state   | meaning
// ST_RUN  | pipeline advancing; flush / load-use resolved each cycle
// ST_WAIT | data memory busy; all stage registers frozen, wait counter running
module hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic       ex_valid, ex_ru_write, ex_mem_read, ex_mem_write;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic       me_valid, me_ru_write, me_mem_read, me_mem_write;
   logic [4:0] me_rd;
   logic       wb_valid, wb_ru_write;
   logic [4:0] wb_rd;

   logic load_use, mem_busy;
   logic freeze_c, stall_c, flush_c, bubble_c;
   logic run_flush, run_stall, run_bubble;

   assign load_use = ex_valid & ex_mem_read & ex_ru_write & (ex_rd != 5'd0) & bus.valid_id &
                     ((bus.rs1_used_id & (bus.rs1_id == ex_rd)) |
                      (bus.rs2_used_id & (bus.rs2_id == ex_rd)));

   assign mem_busy = me_valid & (me_mem_read | me_mem_write) & ~bus.dmem_ready;

   // A taken branch already squashes the dependent instruction, so it wins over load-use.
   assign run_flush  = bus.branch_taken_ex;
   assign run_stall  = ~bus.branch_taken_ex & load_use;
   assign run_bubble = bus.branch_taken_ex | load_use;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      freeze_c   = 1'b0;
      stall_c    = 1'b0;
      flush_c    = 1'b0;
      bubble_c   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               freeze_c   = 1'b1;
               stall_c    = 1'b1;
               state_d    = ST_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               flush_c  = run_flush;
               stall_c  = run_stall;
               bubble_c = run_bubble;
            end
         end
         ST_WAIT: begin
            if (mem_busy) begin
               freeze_c = 1'b1;
               stall_c  = 1'b1;
               if (wait_cnt_q != WAIT_W'(MAX_WAIT))
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
               flush_c    = run_flush;
               stall_c    = run_stall;
               bubble_c   = run_bubble;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
      // Controls must read inactive while reset is held, whatever ID/EX inputs do.
      if (rst) begin
         freeze_c = 1'b0;
         stall_c  = 1'b0;
         flush_c  = 1'b0;
         bubble_c = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (wait_cnt_d >= WAIT_W'(MAX_WAIT))
            timeout_q <= 1'b1;
         if (stall_c)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   // Freeze holds WB as well, so WB-forwarded data stays valid while EX is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_ru_write  <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         me_valid     <= 1'b0;
         me_rd        <= '0;
         me_ru_write  <= 1'b0;
         me_mem_read  <= 1'b0;
         me_mem_write <= 1'b0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_ru_write  <= 1'b0;
      end else if (!freeze_c) begin
         wb_valid     <= me_valid;
         wb_rd        <= me_rd;
         wb_ru_write  <= me_ru_write;
         me_valid     <= ex_valid;
         me_rd        <= ex_rd;
         me_ru_write  <= ex_ru_write;
         me_mem_read  <= ex_mem_read;
         me_mem_write <= ex_mem_write;
         if (bubble_c) begin
            ex_valid     <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_ru_write  <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
         end else begin
            ex_valid     <= bus.valid_id;
            ex_rs1       <= bus.rs1_id;
            ex_rs2       <= bus.rs2_id;
            ex_rd        <= bus.rd_id;
            ex_ru_write  <= bus.ru_write_id;
            ex_mem_read  <= bus.mem_read_id;
            ex_mem_write <= bus.mem_write_id;
         end
      end
   end

   assign bus.rs1_ex      = ex_rs1;
   assign bus.rs2_ex      = ex_rs2;
   assign bus.rd_me       = me_rd;
   assign bus.ru_write_me = me_valid & me_ru_write;
   assign bus.rd_wb       = wb_rd;
   assign bus.ru_write_wb = wb_valid & wb_ru_write;
   assign bus.stall_if    = stall_c;
   assign bus.stall_id    = stall_c;
   assign bus.flush_if_id = flush_c;
   assign bus.bubble_ex   = bubble_c;
   assign bus.freeze      = freeze_c;
   assign bus.mem_timeout = timeout_q;
   assign bus.stall_count = stall_cnt_q;

endmodule
